// File: rtl/aes_round_ctrl_if.sv
// Control/status bundle between the AES round sequencer, the host load path
// and the datapath/key-expansion blocks.
interface aes_round_ctrl_if;
  logic       load;
  logic [1:0] key_size;
  logic       decrypt;
  logic       key_ready;
  logic [3:0] round;
  logic       key_update;
  logic       inverse;
  logic       cipher_complete;
  logic [3:0] operation;

  modport master (
    output load, key_size, decrypt, key_ready,
    input  round, key_update, inverse, cipher_complete, operation
  );

  modport slave (
    input  load, key_size, decrypt, key_ready,
    output round, key_update, inverse, cipher_complete, operation
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks ARK/SUB/SHIFT/MIX for AES-128/192/256 in either
// cipher order, owns the round counter and stalls on key expansion.
module aes_round_ctrl #(
  parameter int SBOX_LAT = 2,
  parameter int MIX_LAT  = 1
) (
  input  logic            clk,
  input  logic            reset,
  aes_round_ctrl_if.slave bus
);

  localparam int LAT_MAX = (SBOX_LAT > MIX_LAT) ? SBOX_LAT : MIX_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);
  localparam logic [CW-1:0] SUB_LAST = CW'(SBOX_LAT - 1);
  localparam logic [CW-1:0] MIX_LAST = CW'(MIX_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARK, S_KEY, S_SUB, S_SHIFT, S_MIX, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_round;
  logic [3:0]    r_nr;
  logic          r_inverse;
  logic [CW-1:0] r_lat;
  logic [3:0]    w_nr;
  logic          w_last_round;

  assign w_last_round = (r_round == r_nr);

  always_comb begin
    case (bus.key_size)
      2'b01:   w_nr = 4'd12;
      2'b10:   w_nr = 4'd14;
      default: w_nr = 4'd10;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!bus.load) w_next = S_ARK;
      S_ARK: begin
        if (w_last_round)                    w_next = S_DONE;
        else if (!r_inverse)                 w_next = S_KEY;
        else if (r_round == 4'd0)            w_next = S_KEY;
        else                                 w_next = S_MIX;
      end
      S_KEY:   if (bus.key_ready) w_next = r_inverse ? S_SHIFT : S_SUB;
      S_SUB:   if (r_lat == SUB_LAST) w_next = r_inverse ? S_ARK : S_SHIFT;
      S_SHIFT: begin
        if (r_inverse)         w_next = S_SUB;
        else if (w_last_round) w_next = S_ARK;
        else                   w_next = S_MIX;
      end
      S_MIX:   if (r_lat == MIX_LAST) w_next = r_inverse ? S_KEY : S_ARK;
      S_DONE:  if (bus.load) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_round   <= 4'd0;
      r_nr      <= 4'd10;
      r_inverse <= 1'b0;
      r_lat     <= '0;
    end else begin
      r_state <= w_next;
      // Latency counter restarts whenever SUB or MIX is (re)entered.
      if (w_next != r_state) r_lat <= '0;
      else if (r_state == S_SUB || r_state == S_MIX) r_lat <= r_lat + 1'b1;

      if (r_state == S_IDLE && !bus.load) begin
        r_nr      <= w_nr;
        r_inverse <= bus.decrypt;
        r_round   <= 4'd0;
      end else if (r_state == S_KEY && bus.key_ready && !w_last_round) begin
        r_round <= r_round + 4'd1;
      end else if (r_state == S_DONE && bus.load) begin
        r_round <= 4'd0;
      end
    end
  end

  assign bus.round           = r_round;
  assign bus.inverse         = r_inverse;
  assign bus.key_update      = (r_state == S_KEY);
  assign bus.cipher_complete = (r_state == S_DONE);

  always_comb begin
    bus.operation = 4'b0000;
    case (r_state)
      S_ARK:   bus.operation = 4'b0001;
      S_SUB:   bus.operation = 4'b0010;
      S_SHIFT: bus.operation = 4'b0100;
      S_MIX:   bus.operation = 4'b1000;
      default: bus.operation = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a per-cycle expected trace is queued at start and
// popped against the DUT outputs; two instances cover default and long latencies.
module tb_aes_round_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b1;
  logic [1:0] key_size = 2'b00;
  logic       decrypt = 1'b0;
  logic       key_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];

  localparam logic [3:0] OP_ARK = 4'b0001, OP_SUB = 4'b0010,
                         OP_SHIFT = 4'b0100, OP_MIX = 4'b1000;

  aes_round_ctrl_if if0();
  aes_round_ctrl_if if1();

  assign if0.load = load;  assign if0.key_size = key_size;
  assign if0.decrypt = decrypt;  assign if0.key_ready = key_ready;
  assign if1.load = load;  assign if1.key_size = key_size;
  assign if1.decrypt = decrypt;  assign if1.key_ready = key_ready;

  aes_round_ctrl dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  aes_round_ctrl #(.SBOX_LAT(4), .MIX_LAT(2)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  always #5 clk = ~clk;

  // {operation, round, key_update, inverse, cipher_complete}
  function automatic logic [10:0] obs(input int sel);
    if (sel == 1)
      return {if1.operation, if1.round, if1.key_update, if1.inverse, if1.cipher_complete};
    return {if0.operation, if0.round, if0.key_update, if0.inverse, if0.cipher_complete};
  endfunction

  task automatic push_e(input logic [3:0] op, input int rnd, input logic ku,
                        input logic inv, input logic dn);
    exp_q.push_back({op, 4'(rnd), ku, inv, dn});
  endtask

  task automatic build_exp(input int s, input int m, input int nr, input logic dec,
                           input int stall_rnd, input int stall_n, input int ndone);
    push_e(OP_ARK, 0, 1'b0, dec, 1'b0);
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k <= ((r == stall_rnd) ? stall_n : 0); k++)
        push_e(4'b0000, r - 1, 1'b1, dec, 1'b0);
      if (!dec) begin
        for (int k = 0; k < s; k++) push_e(OP_SUB, r, 1'b0, dec, 1'b0);
        push_e(OP_SHIFT, r, 1'b0, dec, 1'b0);
        if (r < nr) for (int k = 0; k < m; k++) push_e(OP_MIX, r, 1'b0, dec, 1'b0);
        push_e(OP_ARK, r, 1'b0, dec, 1'b0);
      end else begin
        push_e(OP_SHIFT, r, 1'b0, dec, 1'b0);
        for (int k = 0; k < s; k++) push_e(OP_SUB, r, 1'b0, dec, 1'b0);
        push_e(OP_ARK, r, 1'b0, dec, 1'b0);
        if (r < nr) for (int k = 0; k < m; k++) push_e(OP_MIX, r, 1'b0, dec, 1'b0);
      end
    end
    for (int k = 0; k < ndone; k++) push_e(4'b0000, nr, 1'b0, dec, 1'b1);
  endtask

  task automatic run_op(input int sel, input logic [1:0] ks, input logic dec,
                        input int stall_rnd, input int stall_n, input bit toggle,
                        input bit pre_reset, input string name);
    int s, m, nr, total, stall_left, t, done_at;
    logic [10:0] e, o;
    s = (sel == 1) ? 4 : 2;
    m = (sel == 1) ? 2 : 1;
    nr = (ks == 2'b01) ? 12 : (ks == 2'b10) ? 14 : 10;
    total = 2 + (nr - 1) * (s + m + 3) + (s + 2) + stall_n;
    stall_left = stall_n;
    t = 0;
    done_at = -1;
    @(negedge clk);
    reset = pre_reset; load = 1'b1; key_ready = 1'b1; key_size = ks; decrypt = dec;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    build_exp(s, m, nr, dec, stall_rnd, stall_n, 3);
    load = 1'b0;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      o = obs(sel);
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s trace cycle %0d: got op=%b rnd=%0d ku=%b inv=%b done=%b, need op=%b rnd=%0d ku=%b inv=%b done=%b",
                 name, t, o[10:7], o[6:3], o[2], o[1], o[0], e[10:7], e[6:3], e[2], e[1], e[0]);
      end
      if (done_at < 0 && o[0] === 1'b1) done_at = t;
      if (o[2] === 1'b1 && int'(o[6:3]) == stall_rnd - 1 && stall_left > 0) begin
        key_ready = 1'b0;
        stall_left--;
      end else begin
        key_ready = 1'b1;
      end
      if (toggle && t == 10) begin
        load = 1'b1; key_size = ~ks; decrypt = ~dec;
      end
      if (toggle && t == 14) begin
        load = 1'b0; key_size = ks; decrypt = dec;
      end
      t++;
    end
    n_cmp++;
    if (done_at != total) begin
      n_bad++;
      $display("FAIL %s cycles ARK->DONE: got %0d, need %0d", name, done_at, total);
    end
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o = obs(sel);
    n_cmp++;
    if (o !== {4'b0000, 4'd0, 1'b0, dec, 1'b0}) begin
      n_bad++;
      $display("FAIL %s done->idle: got %b, need %b", name, o, {4'b0000, 4'd0, 1'b0, dec, 1'b0});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs(i) !== 11'd0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: got %b, need %b", i, obs(i), 11'd0);
      end
    end
  endtask

  task automatic test_encrypt_128();
    run_op(0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b1, "enc128");
  endtask

  task automatic test_decrypt_128();
    run_op(0, 2'b00, 1'b1, 0, 0, 1'b0, 1'b1, "dec128");
  endtask

  task automatic test_key_sizes();
    run_op(0, 2'b01, 1'b0, 0, 0, 1'b0, 1'b1, "enc192");
    run_op(0, 2'b10, 1'b0, 0, 0, 1'b0, 1'b1, "enc256");
    run_op(0, 2'b11, 1'b0, 0, 0, 1'b0, 1'b1, "enc_ks11");
    run_op(0, 2'b10, 1'b1, 0, 0, 1'b0, 1'b1, "dec256");
  endtask

  task automatic test_key_stall();
    run_op(0, 2'b00, 1'b0, 4, 3, 1'b0, 1'b1, "key_stall");
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    @(negedge clk);
    reset = 1'b1; load = 1'b1; key_size = 2'b00; decrypt = 1'b1; key_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (if0.operation === OP_MIX && if0.round === 4'd5) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reset_mid reach MIX round 5: got not reached, need reached");
    end
    reset = 1'b1; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (obs(0) !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_mid idle: got %b, need %b", obs(0), 11'd0);
    end
    run_op(0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_latency_params();
    run_op(1, 2'b00, 1'b0, 0, 0, 1'b1, 1'b1, "lat4_2");
  endtask

  initial begin
    test_reset();
    test_encrypt_128();
    test_decrypt_128();
    test_key_sizes();
    test_key_stall();
    test_reset_mid();
    test_latency_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Parametrised successor of the AES round-sequencing FSM; drives the datapath's AddRoundKey, SubBytes, ShiftRows and MixColumns enables plus the key-expansion handshake.
- Adds AES-128/192/256 round counts, encrypt/decrypt ordering, configurable S-box and MixColumns latency, and a key_ready stall.
- Owns the round counter instead of taking the round from the datapath.
- Sits between the SPI load interface and the AES datapath/key-expansion blocks.

Parameters:
- SBOX_LAT, 2, cycles spent in SUB state (>=1); matches the S-box pipeline depth.
- MIX_LAT, 1, cycles spent in MIX state (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  high = host loading key/plaintext; low in IDLE starts an operation
- key_size  in  2  00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11 treated as 00; sampled on the start cycle
- decrypt  in  1  0=encrypt order, 1=inverse-cipher order; sampled on the start cycle
- key_ready  in  1  key expansion has the next round key valid
- round  out  4  current round number, 0..Nr
- key_update  out  1  high every cycle in KEY state
- inverse  out  1  registered copy of the sampled decrypt flag; datapath selects inverse S-box/shift/mix
- cipher_complete  out  1  high in DONE
- operation  out  4  one-hot: [0]=ARK, [1]=SUB, [2]=SHIFT, [3]=MIX; 0 in IDLE/KEY/DONE

Behaviour:
- States: IDLE, ARK, KEY, SUB, SHIFT, MIX, DONE.
- Registered state plus a latency counter. All outputs are Moore-decoded from state/registers.
- Reset (any cycle, including mid-operation) → IDLE, round=0, inverse=0, latency counter=0. All outputs 0 the cycle after reset is sampled.
- IDLE: if load=0, latch Nr from key_size and inverse from decrypt, round<=0, go to ARK. Otherwise stay in IDLE.
- Encrypt transitions:
  - ARK → DONE if round==Nr, else → KEY.
  - KEY: stay while key_ready=0. On key_ready=1, round<=round+1 and go to SUB.
  - SUB: stay exactly SBOX_LAT cycles, then → SHIFT.
  - SHIFT → ARK if round==Nr, else → MIX.
  - MIX: stay exactly MIX_LAT cycles, then → ARK.
- Decrypt transitions:
  - ARK → DONE if round==Nr; → KEY if round==0; else → MIX.
  - MIX: MIX_LAT cycles, then → KEY.
  - KEY: same stall/increment as encrypt, then → SHIFT.
  - SHIFT → SUB.
  - SUB: SBOX_LAT cycles, then → ARK.
- The final round never visits MIX and never visits KEY after its ARK.
- DONE: cipher_complete=1, and round holds Nr.
  - Stay in DONE while load=0.
  - load=1 → IDLE; round resets to 0 on entering IDLE.
- load, key_size and decrypt changes after the start cycle are ignored until IDLE is re-entered; there is no abort except reset.
- Latency counter: 0-based and reloaded on every SUB/MIX entry. Widths are sized by $clog2 of the larger latency + 1.
- round never exceeds Nr and never wraps.
- Total cycles from the first ARK cycle to the first DONE cycle, with key_ready tied high:
  - Formula: 2 + (Nr-1)·(SBOX_LAT+MIX_LAT+3) + (SBOX_LAT+2).
  - Each cycle key_ready is low in KEY adds one cycle.

Test Plan:
- Encrypt AES-128, defaults, key_ready=1, load 1→0 → first DONE 60 cycles after first ARK; operation sequence in round 1 is SUB,SUB,SHIFT,MIX,ARK; round 10 has no MIX; round=10 in DONE.
- Decrypt AES-128, defaults → round-1 sequence SHIFT,SUB,SUB,ARK,MIX,KEY; 60 cycles total; inverse=1 throughout; final ARK → DONE with no MIX.
- key_size=01 → 72 cycles, round ends at 12; key_size=10 → 84 cycles, round ends at 14; key_size=11 → 60 cycles.
- key_ready held low 3 cycles in the round-4 KEY state → key_update high 4 cycles, round increments only on the key_ready cycle, total 63 cycles.
- reset asserted while in MIX of round 5 → next cycle IDLE, operation=0, round=0; a following start runs the full 60 cycles.
- SBOX_LAT=4, MIX_LAT=2 AES-128 encrypt → 2+9·9+6 = 89 cycles; load toggled mid-run is ignored; DONE holds until load=1, then IDLE.
